// File: rtl/yarp_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Data has priority; a starvation counter eventually forces a waiting fetch through.
module yarp_mem_arbiter #(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_ack_o,
  output logic        imem_rd_valid_o,
  output logic [31:0] imem_rd_data_o,
  input  logic        dmem_req_i,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_wr_i,
  input  logic [1:0]  dmem_byte_en_i,
  input  logic [31:0] dmem_wr_data_i,
  output logic        dmem_ack_o,
  output logic        dmem_rd_valid_o,
  output logic [31:0] dmem_rd_data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic [31:0] mem_wr_data_o,
  input  logic [31:0] mem_rd_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT
  } state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(RD_LATENCY - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] lat_cnt;
  logic [7:0] starve_cnt;
  logic       starved;
  logic       grant_d;
  logic       grant_i;
  logic       rd_done;

  // Grants are combinational and gated by reset_n so an asserted reset
  // silences every output in the same cycle, even with requests pending.
  always_comb begin
    starved = imem_req_i && dmem_req_i && (starve_cnt == STARVE_MAX);
    grant_d = reset_n && (state == IDLE) && dmem_req_i && !starved;
    grant_i = reset_n && (state == IDLE) && imem_req_i && !grant_d;
    rd_done = reset_n && (state != IDLE) && (lat_cnt == '0);
  end

  always_comb begin
    imem_ack_o      = grant_i;
    dmem_ack_o      = grant_d;
    mem_req_o       = grant_i || grant_d;
    mem_wr_o        = grant_d && dmem_wr_i;
    mem_addr_o      = '0;
    mem_byte_en_o   = '0;
    mem_wr_data_o   = '0;
    if (grant_d) begin
      mem_addr_o    = dmem_addr_i;
      mem_byte_en_o = dmem_byte_en_i;
      mem_wr_data_o = dmem_wr_data_i;
    end else if (grant_i) begin
      mem_addr_o    = imem_addr_i;
      mem_byte_en_o = 2'b11;
    end
    imem_rd_valid_o = rd_done && (state == I_WAIT);
    dmem_rd_valid_o = rd_done && (state == D_WAIT);
    imem_rd_data_o  = imem_rd_valid_o ? mem_rd_data_i : '0;
    dmem_rd_data_o  = dmem_rd_valid_o ? mem_rd_data_i : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state   <= I_WAIT;
            lat_cnt <= LAT_LOAD;
          end else if (grant_d && !dmem_wr_i) begin
            state   <= D_WAIT;
            lat_cnt <= LAT_LOAD;
          end
        end
        default: begin
          if (lat_cnt == '0) state <= IDLE;
          else lat_cnt <= lat_cnt - 4'd1;
        end
      endcase
      if (!imem_req_i || grant_i) starve_cnt <= '0;
      else if (grant_d && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule
